// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand issuer, alu_pipe and the result consumer.
// The issuer/consumer side uses the master modport; the ALU uses slave.
interface alu_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic [3:0]              op;
  logic                    acc_sel;
  logic                    acc_clr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DATA_WIDTH:0] C;
  logic                    zero;
  logic                    neg;
  logic                    ovf;
  logic                    err;

  modport master (
    output in_valid, A, B, op, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, C, zero, neg, ovf, err
  );

  modport slave (
    input  in_valid, A, B, op, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, C, zero, neg, ovf, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined signed ALU with accumulator operand, HOLD and flags.
// Define ALU_SAT_EN to clamp overflowing arithmetic results instead of wrapping.
module alu_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  localparam int W = DATA_WIDTH + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_BP2  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SAR  = 4'd11;
  localparam logic [3:0] OP_HOLD = 4'd15;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic [3:0]            r_s1_op;
  logic                  r_s1_acc_sel;

  logic                  r_out_valid;
  logic [W-1:0]          r_c;
  logic                  r_zero;
  logic                  r_neg;
  logic                  r_ovf;
  logic                  r_err;

  logic [W-1:0]          r_acc;
  logic [W-1:0]          r_hold_c;
  logic                  r_hold_ovf;

  logic                  w_s1_adv;
  logic                  w_in_fire;
  logic                  w_s2_load;
  logic                  w_acc_load;
  logic [W-1:0]          w_a;
  logic [W-1:0]          w_b;
  logic [W:0]            w_wide;
  logic                  w_arith;
  logic [W-1:0]          w_c;
  logic                  w_ovf;
  logic                  w_err;

  // S2 may take a new beat whenever it is empty or its beat leaves this cycle.
  assign w_s1_adv   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !rst && (!r_s1_valid || w_s1_adv);
  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_s2_load  = r_s1_valid && w_s1_adv;
  assign w_acc_load = w_s2_load && (r_s1_op < 4'd12);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_a     = r_s1_acc_sel ? r_acc : {r_s1_a[DATA_WIDTH-1], r_s1_a};
    w_b     = {r_s1_b[DATA_WIDTH-1], r_s1_b};
    w_wide  = '0;
    w_arith = 1'b0;
    w_c     = '0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    // Arithmetic ops are evaluated one bit wider so overflow is a sign-bit disagreement.
    case (r_s1_op)
      OP_ADD:  begin w_wide = {w_a[W-1], w_a} + {w_b[W-1], w_b}; w_arith = 1'b1; end
      OP_SUB:  begin w_wide = {w_a[W-1], w_a} - {w_b[W-1], w_b}; w_arith = 1'b1; end
      OP_DEC:  begin w_wide = {w_a[W-1], w_a} - (W+1)'(1);        w_arith = 1'b1; end
      OP_BP2:  begin w_wide = {w_b[W-1], w_b} + (W+1)'(2);        w_arith = 1'b1; end
      OP_SHL:  begin w_wide = {w_a, 1'b0};                        w_arith = 1'b1; end
      OP_AND:  w_c = w_a & w_b;
      OP_OR:   w_c = w_a | w_b;
      OP_XOR:  w_c = w_a ^ w_b;
      OP_XNOR: w_c = ~(w_a ^ w_b);
      OP_NAND: w_c = ~(w_a & w_b);
      OP_PASS: w_c = w_a;
      OP_SAR:  w_c = {w_a[W-1], w_a[W-1:1]};
      OP_HOLD: begin w_c = r_hold_c; w_ovf = r_hold_ovf; end
      default: w_err = 1'b1;
    endcase
    if (w_arith) begin
      w_ovf = w_wide[W] ^ w_wide[W-1];
      w_c   = w_wide[W-1:0];
`ifdef ALU_SAT_EN
      if (w_ovf) w_c = w_wide[W] ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, {DATA_WIDTH{1'b1}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_hold_c    <= '0;
      r_hold_ovf  <= 1'b0;
    end else begin
      if (w_in_fire)     r_s1_valid <= 1'b1;
      else if (w_s1_adv) r_s1_valid <= 1'b0;

      if (w_s1_adv) r_out_valid <= r_s1_valid;

      if (w_s2_load) begin
        r_c    <= w_c;
        r_zero <= (w_c == '0);
        r_neg  <= w_c[W-1];
        r_ovf  <= w_ovf;
        r_err  <= w_err;
        if (r_s1_op != OP_HOLD) begin
          r_hold_c   <= w_c;
          r_hold_ovf <= w_ovf;
        end
      end

      // A clear pulse wins over a same-cycle load.
      if (bus.acc_clr)     r_acc <= '0;
      else if (w_acc_load) r_acc <= w_c;
    end
  end

  // NOTE: payload registers carry no reset; r_s1_valid alone says whether their contents matter.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_a       <= bus.A;
      r_s1_b       <= bus.B;
      r_s1_op      <= bus.op;
      r_s1_acc_sel <= bus.acc_sel;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.C         = r_c;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_alu_pipe;
  localparam int DW   = 8;
  localparam int W    = DW + 1;
  localparam int MAXV = (1 << DW) - 1;
  localparam int MINV = -(1 << DW);

  typedef struct {
    int a;
    int b;
    int op;
    bit sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.DATA_WIDTH(DW)) bus ();
  alu_pipe #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t pend[$];      // accepted beats whose result has not yet appeared
  bit    s2_full = 0;  // a result is being presented on the output

  task automatic check(input string name, input integer act, input integer exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of one operation straight from the opcode table, in plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int c, output bit ovf, output bit err);
    int exact;
    bit arith;
    logic [W-1:0] va, vb, vl;
    va = a[W-1:0];
    vb = b[W-1:0];
    vl = '0;
    exact = 0; arith = 1; ovf = 0; err = 0; c = 0;
    case (op)
      0:  exact = a + b;
      1:  exact = a - b;
      7:  exact = a - 1;
      8:  exact = b + 2;
      10: exact = a * 2;
      2:  begin arith = 0; vl = va & vb;    c = int'($signed(vl)); end
      3:  begin arith = 0; vl = va | vb;    c = int'($signed(vl)); end
      4:  begin arith = 0; vl = va ^ vb;    c = int'($signed(vl)); end
      5:  begin arith = 0; vl = ~(va ^ vb); c = int'($signed(vl)); end
      6:  begin arith = 0; vl = ~(va & vb); c = int'($signed(vl)); end
      9:  begin arith = 0; c = a; end
      11: begin arith = 0; c = a >>> 1; end
      default: begin arith = 0; c = 0; err = 1; end
    endcase
    if (arith) begin
      ovf = (exact > MAXV) || (exact < MINV);
      c = exact;
      if (c > MAXV) c -= (1 << W);
      if (c < MINV) c += (1 << W);
`ifdef ALU_SAT_EN
      if (ovf) c = (exact > MAXV) ? MAXV : MINV;
`endif
    end
  endfunction

  // Reference model and per-cycle compare. Handshakes are sampled mid-cycle, results after the edge.
  initial begin : monitor
    bit    s_rst, s_inf, s_ovld, s_ordy, s_clr, appear;
    beat_t s_beat, cur;
    int    acc, hold_c, ec, a_op;
    bit    hold_ovf, eovf, eerr;
    acc = 0; hold_c = 0; hold_ovf = 0; ec = 0; eovf = 0; eerr = 0;
    forever begin
      @(negedge clk);
      s_rst      = rst;
      s_inf      = bus.in_valid && bus.in_ready;
      s_ovld     = bus.out_valid;
      s_ordy     = bus.out_ready;
      s_clr      = bus.acc_clr;
      s_beat.a   = int'($signed(bus.A));
      s_beat.b   = int'($signed(bus.B));
      s_beat.op  = int'(bus.op);
      s_beat.sel = bus.acc_sel;
      check("in_ready", bus.in_ready,
            (!rst && !((pend.size() + int'(s2_full)) >= 2 && !bus.out_ready)) ? 1 : 0);
      @(posedge clk);
      #2;
      if (s_rst) begin
        pend.delete();
        s2_full = 0; acc = 0; hold_c = 0; hold_ovf = 0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_C", bus.C, 0);
        check("rst_flags", {bus.zero, bus.neg, bus.ovf, bus.err}, 0);
      end else begin
        appear = (bus.out_valid === 1'b1) && (!s_ovld || s_ordy);
        if (appear) begin
          check("beat_pending", (pend.size() > 0) ? 1 : 0, 1);
          if (pend.size() > 0) begin
            cur  = pend.pop_front();
            a_op = cur.sel ? acc : cur.a;
            if (cur.op == 15) begin
              ec = hold_c; eovf = hold_ovf; eerr = 0;
            end else begin
              model(cur.op, a_op, cur.b, ec, eovf, eerr);
              hold_c = ec; hold_ovf = eovf;
            end
            if (cur.op < 12) acc = ec;
          end
          s2_full = 1;
        end else if (s_ovld && s_ordy) begin
          s2_full = 0;
        end
        if (s_clr) acc = 0;
        if (s_inf) pend.push_back(s_beat);
        check("out_valid", bus.out_valid, s2_full);
        if (s2_full) begin
          check("C", bus.C, ec);
          check("zero", bus.zero, (ec == 0) ? 1 : 0);
          check("neg", bus.neg, (ec < 0) ? 1 : 0);
          check("ovf", bus.ovf, eovf);
          check("err", bus.err, eerr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; called and returns at posedge+1.
  task automatic send(input int a, input int b, input int op, input bit sel);
    int k;
    bus.in_valid = 1'b1;
    bus.A        = DW'(a);
    bus.B        = DW'(b);
    bus.op       = 4'(op);
    bus.acc_sel  = sel;
    k = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_accepted", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result, compare it, and let it drain (out_ready must be 1).
  task automatic wait_out(input string name, input int c, input bit o, input bit e);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_C"}, bus.C, c);
    check({name, "_ovf"}, bus.ovf, o);
    check({name, "_err"}, bus.err, e);
    tick();
  endtask

  initial begin : driver
    int acc_cnt;
    bus.in_valid = 0; bus.A = '0; bus.B = '0; bus.op = '0;
    bus.acc_sel = 0; bus.acc_clr = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single beat, two-edge latency.
    send(100, 27, 0, 0);
    @(posedge clk);
    #2;
    check("t1_valid", bus.out_valid, 1);
    check("t1_C", bus.C, 127);
    check("t1_flags", {bus.zero, bus.neg, bus.ovf}, 0);
    tick();

    // Eight back-to-back subtractions, one result per cycle.
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          bus.in_valid = 1; bus.A = DW'(i); bus.B = DW'(2 * i); bus.op = 4'd1; bus.acc_sel = 0;
          @(negedge clk);
          check("t2_in_ready", bus.in_ready, 1);
          tick();
        end
        bus.in_valid = 0;
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        for (int i = 1; i <= 8; i++) begin
          check("t2_valid", bus.out_valid, 1);
          check("t2_C", bus.C, -i);
          @(negedge clk);
        end
      end
    join
    tick();

    // Backpressure: consumer stalls for five cycles while the issuer keeps offering beats.
    bus.out_ready = 0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.A = DW'(10 + acc_cnt); bus.B = DW'(1); bus.op = 4'd0; bus.acc_sel = 0;
      @(negedge clk);
      if (bus.in_ready === 1'b1) acc_cnt++;
      tick();
    end
    check("t3_accepted", acc_cnt, 2);
    @(negedge clk);
    check("t3_in_ready_low", bus.in_ready, 0);
    check("t3_C_held", bus.C, 11);
    tick();
    bus.in_valid = 0;
    bus.out_ready = 1;
    wait_out("t3_first", 11, 0, 0);
    wait_out("t3_second", 12, 0, 0);
    @(negedge clk);
    check("t3_no_dup", bus.out_valid, 0);
    tick();

    // Accumulator chaining with overflow on the third step.
    bus.acc_clr = 1;
    tick();
    bus.acc_clr = 0;
    fork
      begin
        send(127, 0, 9, 0);
        send(0, 127, 0, 1);
        send(0, 127, 0, 1);
      end
      begin
        wait_out("t4_pass", 127, 0, 0);
        wait_out("t4_acc1", 254, 0, 0);
`ifdef ALU_SAT_EN
        wait_out("t4_acc2", 255, 1, 0);
`else
        wait_out("t4_acc2", -131, 1, 0);
`endif
      end
    join

    // Reserved opcodes and HOLD.
    fork
      begin
        send(0, 0, 13, 0);
        send(0, 0, 15, 0);
        send(5, 0, 9, 0);
        send(0, 0, 15, 0);
        send(0, 0, 12, 0);
        send(0, 0, 9, 1);
      end
      begin
        wait_out("t5_rsv", 0, 0, 1);
        wait_out("t5_hold0", 0, 0, 0);
        wait_out("t5_pass5", 5, 0, 0);
        wait_out("t5_hold5", 5, 0, 0);
        wait_out("t5_rsv2", 0, 0, 1);
        wait_out("t5_acc_kept", 5, 0, 0);
      end
    join

    // Reset with both stages full discards everything and clears the accumulator.
    bus.out_ready = 0;
    send(1, 1, 0, 0);
    send(2, 2, 0, 0);
    @(negedge clk);
    check("t6_full_in_ready", bus.in_ready, 0);
    tick();
    rst = 1;
    @(negedge clk);
    check("t6_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #2;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_C", bus.C, 0);
    rst = 0;
    bus.out_ready = 1;
    tick();
    send(77, 0, 9, 1);
    wait_out("t6_acc_zero", 0, 0, 0);

    // Randomized traffic with stalls, clears and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.A         = DW'($urandom_range(0, 255));
      bus.B         = DW'($urandom_range(0, 255));
      bus.op        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                  : 4'($urandom_range(0, 11));
      bus.acc_sel   = 1'($urandom_range(0, 1));
      bus.acc_clr   = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 499) == 0);
      tick();
    end
    bus.in_valid = 0; bus.acc_clr = 0; bus.out_ready = 1; rst = 0;
    repeat (6) tick();
    check("drain_pending", pend.size(), 0);
    check("drain_s2", s2_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
